// File: rtl/dmem_seq_arbiter.sv
// dmem_seq_arbiter
//   Arbitrates a CPU MEM-stage port and a debug/loader port onto a byte-wide
//   data memory. Each 32-bit word access is run as four big-endian byte beats
//   (MSB first). The access occupies the block for six cycles: the granting
//   IDLE cycle, four XFER beats, and one DONE cycle.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   cpu_req/we/addr/wdata  CPU word request (addr is a word address; [1:0] ignored)
//   cpu_rdata, cpu_done    CPU load result (held) and one-cycle completion pulse
//   cpu_stall              cpu_req & ~cpu_done, freezes the pipeline
//   dbg_req/we/addr/wdata  debug word request
//   dbg_rdata, dbg_done    debug read result (held) and completion pulse
//   mem_addr/we/wdata      byte address, byte write strobe, byte write data
//   mem_rdata              byte read data, combinational from mem_addr
//   busy                   high whenever the FSM is not IDLE
module dmem_seq_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic [31:0]       dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  // Latched request. Only the word-aligned part of the address is kept:
  // the beat counter supplies the low two bits.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-3:0] addr_hi;
    logic [31:0]       wdata;
  } req_t;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic        gnt_dbg_q, gnt_dbg_d;   // 1: current transaction belongs to dbg
  logic        last_dbg_q, last_dbg_d; // 1: dbg was served most recently
  req_t        req_q, req_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic        pick_dbg;
  logic        xfer;
  logic [31:0] rd_word;
  logic [7:0]  wr_byte;

  // Byte offset bits of the word addresses are intentionally dropped.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{cpu_addr[1:0], dbg_addr[1:0]};

  // dbg wins only if cpu is idle, or on a tie when cpu was served last.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
  assign xfer     = (state_q == XFER);

  // Current read buffer with this beat's byte merged in, MSB byte first.
  always_comb begin
    rd_word = rbuf_q;
    case (beat_q)
      2'd0: rd_word[31:24] = mem_rdata;
      2'd1: rd_word[23:16] = mem_rdata;
      2'd2: rd_word[15:8]  = mem_rdata;
      default: rd_word[7:0] = mem_rdata;
    endcase
  end

  always_comb begin
    case (beat_q)
      2'd0: wr_byte = req_q.wdata[31:24];
      2'd1: wr_byte = req_q.wdata[23:16];
      2'd2: wr_byte = req_q.wdata[15:8];
      default: wr_byte = req_q.wdata[7:0];
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    gnt_dbg_d   = gnt_dbg_q;
    last_dbg_d  = last_dbg_q;
    req_d       = req_q;
    rbuf_d      = rbuf_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          gnt_dbg_d  = pick_dbg;
          last_dbg_d = pick_dbg;
          req_d      = pick_dbg ? req_t'{dbg_we, dbg_addr[ADDR_W-1:2], dbg_wdata}
                                : req_t'{cpu_we, cpu_addr[ADDR_W-1:2], cpu_wdata};
          beat_d     = 2'd0;
          state_d    = XFER;
        end
      end
      XFER: begin
        if (!req_q.we) rbuf_d = rd_word;
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = DONE;
          // Result becomes visible on the same edge that enters DONE.
          if (!req_q.we) begin
            if (gnt_dbg_q) dbg_rdata_d = rd_word;
            else           cpu_rdata_d = rd_word;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= 2'd0;
      gnt_dbg_q   <= 1'b0;
      last_dbg_q  <= 1'b1;
      req_q       <= '0;
      rbuf_q      <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      gnt_dbg_q   <= gnt_dbg_d;
      last_dbg_q  <= last_dbg_d;
      req_q       <= req_d;
      rbuf_q      <= rbuf_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  // Memory side is quiet outside XFER. The strobe is also gated by rst_n so
  // that a beat coinciding with reset never writes its byte.
  assign mem_addr  = xfer ? {req_q.addr_hi, beat_q} : '0;
  assign mem_we    = xfer & req_q.we & rst_n;
  assign mem_wdata = (xfer & req_q.we) ? wr_byte : 8'h00;

  assign cpu_done  = (state_q == DONE) & ~gnt_dbg_q;
  assign dbg_done  = (state_q == DONE) &  gnt_dbg_q;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign busy      = (state_q != IDLE);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule
